// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU constants: forwarding-select encodings, next-PC codes and the
// shadow pipeline-stage record used by the hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } stage_t;

  // True when an operand read of src is produced by a stage writing dst.
  // r0 is hard-wired, so it never matches.
  function automatic logic reg_hit(input logic reads, input logic [4:0] src,
                                   input logic wr, input logic [4:0] dst);
    return reads & wr & (dst == src) & (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding mux select: the youngest producer (EX) wins over MEM,
// except that a load still in EX cannot forward and is left to the stall logic.
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       reads,
  input  logic [4:0] src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  output logic [1:0] sel
);

  always_comb begin
    // NOTE: default first, so every path through the block assigns sel and no latch is inferred.
    sel = FWD_RF;
    if (reg_hit(reads, src, ewreg & ~em2reg, ern)) begin
      sel = FWD_EX_ALU;
    end else if (reg_hit(reads, src, mwreg, mrn)) begin
      sel = mm2reg ? FWD_MEM_LD : FWD_MEM_ALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush,
// memory freeze, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             wreg,
  input  logic             m2reg,
  input  logic [4:0]       rn,
  input  logic [1:0]       pcsource,
  input  logic             mem_busy,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t ex_q;
  stage_t mem_q;
  stage_t id_info;
  logic   ld_use;

  fwd_sel u_fwd_a (
    .reads (use_rs),
    .src   (rs),
    .ewreg (ex_q.wreg),
    .em2reg(ex_q.m2reg),
    .ern   (ex_q.rn),
    .mwreg (mem_q.wreg),
    .mm2reg(mem_q.m2reg),
    .mrn   (mem_q.rn),
    .sel   (fwda)
  );

  fwd_sel u_fwd_b (
    .reads (use_rt),
    .src   (rt),
    .ewreg (ex_q.wreg),
    .em2reg(ex_q.m2reg),
    .ern   (ex_q.rn),
    .mwreg (mem_q.wreg),
    .mm2reg(mem_q.m2reg),
    .mrn   (mem_q.rn),
    .sel   (fwdb)
  );

  // A load in EX has no data yet; any dependent reader must wait one cycle.
  assign ld_use = ex_q.m2reg &
                  (reg_hit(use_rs, rs, ex_q.wreg, ex_q.rn) |
                   reg_hit(use_rt, rt, ex_q.wreg, ex_q.rn));

  assign freeze = mem_busy;
  assign bubble = ld_use & ~freeze;
  assign wpcir  = ~(ld_use | freeze);
  // A stall outranks a redirect: the branch is re-evaluated once operands are valid.
  assign flush  = (pcsource != PC_SEQ) & ~ld_use & ~freeze;

  always_comb begin
    id_info = bubble ? stage_t'('0) : '{wreg: wreg, m2reg: m2reg, rn: rn};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so MEM captures the old EX value, not this edge's update.
    if (clrn) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!freeze) begin
      ex_q  <= id_info;
      mem_q <= ex_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!wpcir && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != CNT_MAX)  flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use stall, flush,
// freeze, reset-during-stall and counter saturation on a 4-bit instance.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clrn, clrn4;
  logic [4:0] rs, rt, rn;
  logic       use_rs, use_rt, wreg, m2reg;
  logic [1:0] pcsource;
  logic       mem_busy, mem_busy4;

  logic [1:0]  fwda, fwdb;
  logic        wpcir, bubble, flush, freeze;
  logic [31:0] stall_cnt, flush_cnt;

  logic [1:0] fwda4, fwdb4;
  logic       wpcir4, bubble4, flush4, freeze4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .wreg(wreg), .m2reg(m2reg), .rn(rn), .pcsource(pcsource), .mem_busy(mem_busy),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble), .flush(flush),
    .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn4), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .wreg(wreg), .m2reg(m2reg), .rn(rn), .pcsource(pcsource), .mem_busy(mem_busy4),
    .fwda(fwda4), .fwdb(fwdb4), .wpcir(wpcir4), .bubble(bubble4), .flush(flush4),
    .freeze(freeze4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] a, input logic [4:0] b, input logic ua,
                    input logic ub, input logic w, input logic m, input logic [4:0] d);
    rs = a; rt = b; use_rs = ua; use_rt = ub; wreg = w; m2reg = m; rn = d;
    #2;
  endtask

  initial begin
    clrn = 1'b1; clrn4 = 1'b1; mem_busy = 1'b0; mem_busy4 = 1'b0; pcsource = 2'b00;
    id(0, 0, 0, 0, 0, 0, 0);
    tick();
    clrn = 1'b0;
    #2;
    check("reset_fwda", fwda, 2'b00);
    check("reset_fwdb", fwdb, 2'b00);
    check("reset_bubble", bubble, 1'b0);
    check("reset_wpcir", wpcir, 1'b1);
    check("reset_flush", flush, 1'b0);
    check("reset_freeze", freeze, 1'b0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);

    // add r3 then reader of r3
    id(0, 0, 0, 0, 1, 0, 3);
    tick();
    id(3, 0, 1, 0, 0, 0, 0);
    check("add_ex_fwda", fwda, 2'b01);
    check("add_ex_wpcir", wpcir, 1'b1);
    tick(); #2;
    check("add_mem_fwda", fwda, 2'b10);

    // r4 written in both EX and MEM: EX wins
    id(0, 0, 0, 0, 1, 0, 4);
    tick();
    tick();
    id(0, 4, 0, 1, 0, 0, 0);
    check("prio_fwdb", fwdb, 2'b01);
    tick(); #2;
    check("prio_mem_fwdb", fwdb, 2'b10);

    // load r5 then reader of r5 via rt
    id(0, 0, 0, 0, 1, 1, 5);
    tick();
    id(0, 5, 0, 1, 1, 0, 6);
    check("ld_use_bubble", bubble, 1'b1);
    check("ld_use_wpcir", wpcir, 1'b0);
    check("ld_use_fwdb", fwdb, 2'b00);
    tick(); #2;
    check("ld_after_fwdb", fwdb, 2'b11);
    check("ld_after_wpcir", wpcir, 1'b1);
    check("ld_after_bubble", bubble, 1'b0);
    check("ld_stall_cnt", stall_cnt, 1);
    tick();

    // load into r0 followed by r0 readers: nothing happens
    id(0, 0, 0, 0, 1, 1, 0);
    tick();
    id(0, 0, 1, 1, 0, 0, 0);
    check("r0_fwda", fwda, 2'b00);
    check("r0_fwdb", fwdb, 2'b00);
    check("r0_bubble", bubble, 1'b0);
    check("r0_wpcir", wpcir, 1'b1);
    tick();

    // load-use coinciding with a branch
    id(0, 0, 0, 0, 1, 1, 7);
    tick();
    pcsource = 2'b01;
    id(7, 0, 1, 0, 0, 0, 0);
    check("br_stall_flush", flush, 1'b0);
    check("br_stall_bubble", bubble, 1'b1);
    check("br_stall_wpcir", wpcir, 1'b0);
    tick(); #2;
    check("br_retry_flush", flush, 1'b1);
    check("br_retry_fwda", fwda, 2'b11);
    check("br_retry_wpcir", wpcir, 1'b1);
    tick();
    pcsource = 2'b00;
    id(0, 0, 0, 0, 0, 0, 0);
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 2);

    // add r2 held in EX while memory is busy for 3 cycles
    id(0, 0, 0, 0, 1, 0, 2);
    tick();
    mem_busy = 1'b1;
    pcsource = 2'b01;
    id(2, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("frz_freeze", freeze, 1'b1);
      check("frz_wpcir", wpcir, 1'b0);
      check("frz_flush", flush, 1'b0);
      check("frz_fwda", fwda, 2'b01);
      tick(); #2;
    end
    mem_busy = 1'b0;
    pcsource = 2'b00;
    #1;
    check("frz_end_fwda", fwda, 2'b01);
    check("frz_end_freeze", freeze, 1'b0);
    check("frz_end_wpcir", wpcir, 1'b1);
    check("frz_stall_cnt", stall_cnt, 5);
    check("frz_flush_cnt", flush_cnt, 1);
    tick(); #2;
    check("frz_adv_fwda", fwda, 2'b10);

    // reset asserted during a load-use stall
    id(0, 0, 0, 0, 1, 1, 9);
    tick();
    id(9, 0, 1, 0, 0, 0, 0);
    check("rst_stall_bubble", bubble, 1'b1);
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    #2;
    check("rst_drop_bubble", bubble, 1'b0);
    check("rst_drop_wpcir", wpcir, 1'b1);
    check("rst_drop_fwda", fwda, 2'b00);
    check("rst_drop_stall_cnt", stall_cnt, 0);
    check("rst_drop_flush_cnt", flush_cnt, 0);

    // 4-bit counter saturation
    id(0, 0, 0, 0, 0, 0, 0);
    clrn4 = 1'b0;
    mem_busy4 = 1'b1;
    repeat (12) tick();
    #2;
    check("sat_pre_stall_cnt4", stall_cnt4, 12);
    repeat (20) tick();
    #2;
    check("sat_stall_cnt4", stall_cnt4, 15);
    mem_busy4 = 1'b0;
    #1;
    check("sat_wpcir4", wpcir4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of each performance counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clrn, input, 1, the reset; it is synchronous and active-high (1 = clear) in this block.
REQ-004 The block SHALL have port rs, input, 5, the ID-stage source register A number.
REQ-005 The block SHALL have port rt, input, 5, the ID-stage source register B number.
REQ-006 The block SHALL have ports use_rs and use_rt, input, 1 each, which are high when the ID instruction reads that operand.
REQ-007 The block SHALL have ports wreg, m2reg and rn, input, 1/1/5, the ID instruction's write enable, load flag and destination register.
REQ-008 The block SHALL have port pcsource, input, 2, the ID next-PC select; 00 means sequential.
REQ-009 The block SHALL have port mem_busy, input, 1, high while data memory cannot complete this cycle.
REQ-010 The block SHALL have ports fwda and fwdb, output, 2 each: 00 = regfile, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
REQ-011 The block SHALL have port wpcir, output, 1, the write enable for the PC and IF/ID registers.
REQ-012 The block SHALL have port bubble, output, 1, which forces a NOP (wreg = 0, wmem = 0) into ID/EX.
REQ-013 The block SHALL have port flush, output, 1, which squashes the IF/ID contents on the next edge.
REQ-014 The block SHALL have port freeze, output, 1, which holds all pipeline registers, including EX/MEM and MEM/WB.
REQ-015 The block SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, the performance counters.

Function
REQ-016 The block SHALL track two shadow stages, EX {ewreg, em2reg, ern} and MEM {mwreg, mm2reg, mrn}.
REQ-017 On each edge with freeze = 0, the shadow stages SHALL advance: EX <= ID info (or zeros if bubble), MEM <= EX.
REQ-018 On each edge with freeze = 1, both shadow stages SHALL hold their values.
REQ-019 fwda SHALL be combinational and follow this priority:
- 01 if use_rs & ewreg & ~em2reg & ern == rs & ern != 0;
- otherwise 10 or 11 (11 if mm2reg) if use_rs & mwreg & mrn == rs & mrn != 0;
- otherwise 00.
REQ-020 fwdb SHALL follow the same rules with rt and use_rt in place of rs and use_rs.
REQ-021 Register 0 SHALL never cause forwarding or a stall.
REQ-022 The block SHALL compute ld_use = ewreg & em2reg & ern != 0 & ((use_rs & ern == rs) | (use_rt & ern == rt)).
REQ-023 freeze SHALL equal mem_busy.
REQ-024 bubble SHALL equal ld_use & ~freeze.
REQ-025 wpcir SHALL equal ~(ld_use | freeze).
REQ-026 flush SHALL equal (pcsource != 00) & ~ld_use & ~freeze.
REQ-027 When a stall coincides with a branch or jump, the stall SHALL win; the branch is re-evaluated in the following cycle with valid operands.
REQ-028 A load-use stall SHALL last exactly one cycle; afterwards the load sits in MEM and fwd = 11.
REQ-029 stall_cnt SHALL increment on every edge where wpcir = 0.
REQ-030 flush_cnt SHALL increment on every edge where flush = 1.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 All outputs except the counters SHALL be combinational from the inputs and shadow state, with zero-cycle latency.

Reset
REQ-033 While clrn = 1 at an edge, the EX and MEM shadow stages and both counters SHALL be cleared to 0.
REQ-034 With shadows cleared, the outputs SHALL be fwda = fwdb = 00 and bubble = 0; wpcir, flush and freeze follow only mem_busy and pcsource.
REQ-035 A reset asserted during a stall or freeze SHALL drop the pending hazard, with no stall in the next cycle.

Structure
REQ-036 The forwarding-select encodings (00/01/10/11) and the pcsource sequential code SHALL be constants in the shared CPU package.
REQ-037 Forwarding logic SHALL be one sub-module, fwd_sel, instantiated once per operand.
REQ-038 The hazard equations, shadow registers and counters SHALL stay in the top level.

Verification
REQ-039 Add r3 (wreg = 1, rn = 3), then next cycle an instruction with use_rs = 1 and rs = 3 -> fwda = 01, wpcir = 1.
REQ-040 Load r5 (m2reg = 1), then next cycle use_rt = 1 and rt = 5 -> bubble = 1 and wpcir = 0 for one cycle, then fwdb = 11 with wpcir = 1; stall_cnt = 1.
REQ-041 Write to r0 in EX with use_rs = 1 and rs = 0 -> fwda = 00, no stall.
REQ-042 Load-use hazard with pcsource = 01 in the same cycle -> flush = 0 in that cycle, then flush = 1 in the next cycle; flush_cnt = 1.
REQ-043 mem_busy high for 3 cycles with an add r2 in EX -> freeze = 1 and wpcir = 0 for 3 cycles, ern = 2 held, stall_cnt = 3.
REQ-044 Preload stall_cnt near saturation with CNT_W = 4, then hold mem_busy = 1 for 20 cycles -> stall_cnt = 15, no wrap.
